// File: rtl/apb_pkg.sv
// Shared types and default widths for the parametrised APB memory slave.
package apb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StWait,
    StAccess,
    StResp
  } apb_state_e;

  localparam int unsigned DefDataW    = 8;
  localparam int unsigned DefAddrW    = 8;
  localparam int unsigned DefSelW     = 2;
  localparam int unsigned DefWaitW    = 8;
  localparam int unsigned DefMemDepth = 256;
  localparam int unsigned DefTimeout  = 16;

endpackage

// File: rtl/apb_wait_timer.sv
// Loadable down-counter; done is high while the count sits at 1, so a load of N
// followed by N decrementing cycles reports done on the last of them.
module apb_wait_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/apb_mem_slave_p.sv
// APB slave bridging to a memory target with wait states, address-range check,
// ready handshake with optional timeout and an error response.
module apb_mem_slave_p
  import apb_pkg::*;
#(
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned ADDR_W    = DefAddrW,
  parameter int unsigned SEL_W     = DefSelW,
  parameter int unsigned WAIT_W    = DefWaitW,
  parameter int unsigned MEM_DEPTH = DefMemDepth,
  parameter int unsigned TIMEOUT   = DefTimeout
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SEL_W-1:0]  id,
  input  logic [SEL_W-1:0]  sel,
  input  logic              enable,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [WAIT_W-1:0] wait_cycles,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              error,
  output logic              mem_ce,
  output logic              mem_wren,
  output logic              mem_rden,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  input  logic              mem_error
);

  // One counter serves both WAIT and the ACCESS timeout, so size it for either.
  localparam int unsigned TmoW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned CntW = (WAIT_W > TmoW) ? WAIT_W : TmoW;

  apb_state_e        state_d, state_q;
  logic              ready_d, ready_q;
  logic              error_d, error_q;
  logic [DATA_W-1:0] rdata_d, rdata_q;
  logic              ce_d, ce_q;
  logic              wren_d, wren_q;
  logic              rden_d, rden_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [DATA_W-1:0] wdata_d, wdata_q;
  logic              write_d, write_q;
  logic [WAIT_W-1:0] wait_d, wait_q;

  logic            tmr_load, tmr_dec, tmr_done;
  logic [CntW-1:0] tmr_val;
  logic            selected, abort, out_of_range;

  assign selected     = (sel == id);
  assign abort        = !selected || !enable;
  assign out_of_range = (32'(addr_q) >= MEM_DEPTH);

  apb_wait_timer #(
    .CNT_W (CntW)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .done     (tmr_done)
  );

  always_comb begin
    state_d  = state_q;
    ready_d  = 1'b0;
    error_d  = 1'b0;
    rdata_d  = rdata_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    wait_d   = wait_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = 1'b0;
    case (state_q)
      StIdle: begin
        if (selected && !enable) begin
          addr_d  = addr;
          wdata_d = wdata;
          write_d = write;
          wait_d  = wait_cycles;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (abort) begin
          state_d = StIdle;
        end else if (out_of_range) begin
          state_d = StResp;
          ready_d = 1'b1;
          error_d = 1'b1;
        end else if (wait_q == '0) begin
          state_d  = StAccess;
          tmr_load = 1'b1;
          tmr_val  = CntW'(TIMEOUT);
        end else begin
          state_d  = StWait;
          tmr_load = 1'b1;
          tmr_val  = CntW'(wait_q);
        end
      end
      StWait: begin
        tmr_dec = 1'b1;
        if (abort) begin
          state_d = StIdle;
        end else if (tmr_done) begin
          state_d  = StAccess;
          tmr_load = 1'b1;
          tmr_val  = CntW'(TIMEOUT);
        end
      end
      StAccess: begin
        tmr_dec = 1'b1;
        if (abort) begin
          state_d = StIdle;
        end else if (mem_ready) begin
          state_d = StResp;
          ready_d = 1'b1;
          error_d = mem_error;
          if (!write_q) begin
            rdata_d = mem_error ? '0 : mem_rdata;
          end
        end else if ((TIMEOUT != 0) && tmr_done) begin
          state_d = StResp;
          ready_d = 1'b1;
          error_d = 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    ce_d   = (state_d == StAccess);
    wren_d = ce_d && write_q;
    rden_d = ce_d && !write_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      rdata_q <= '0;
      ce_q    <= 1'b0;
      wren_q  <= 1'b0;
      rden_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      error_q <= error_d;
      rdata_q <= rdata_d;
      ce_q    <= ce_d;
      wren_q  <= wren_d;
      rden_q  <= rden_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      wait_q  <= wait_d;
    end
  end

  assign ready     = ready_q;
  assign error     = error_q;
  assign rdata     = rdata_q;
  assign mem_ce    = ce_q;
  assign mem_wren  = wren_q;
  assign mem_rden  = rden_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_apb_mem_slave_p.sv
// Bench for apb_mem_slave_p: vector table, randomized transfers against a
// transaction-level model, and hand-written abort/back-to-back/reset sequences.
module tb_apb_mem_slave_p;

  localparam int DEPTH = 128;
  localparam int TMO   = 4;
  localparam logic [1:0] ID = 2'd1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] sel = '0;
  logic       enable = 1'b0, write = 1'b0;
  logic [7:0] addr = '0, wdata = '0, wait_cycles = '0;
  logic       ready, error, mem_ce, mem_wren, mem_rden;
  logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic       mem_ready, mem_error;

  // Memory device: responds after delay_cfg cycles of mem_ce
  logic [7:0] dev_mem [256];
  int         ce_cnt = 0;
  int         delay_cfg = 0;
  logic       merr_cfg = 1'b0;
  logic       mem_init = 1'b1;

  // Transaction-level reference state
  logic [7:0] ref_mem [256];
  logic [7:0] ref_rdata = '0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  apb_mem_slave_p #(
    .DATA_W    (8),
    .ADDR_W    (8),
    .SEL_W     (2),
    .WAIT_W    (8),
    .MEM_DEPTH (DEPTH),
    .TIMEOUT   (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .id          (ID),
    .sel         (sel),
    .enable      (enable),
    .write       (write),
    .addr        (addr),
    .wdata       (wdata),
    .wait_cycles (wait_cycles),
    .ready       (ready),
    .rdata       (rdata),
    .error       (error),
    .mem_ce      (mem_ce),
    .mem_wren    (mem_wren),
    .mem_rden    (mem_rden),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .mem_error   (mem_error)
  );

  assign mem_ready = (ce_cnt >= delay_cfg);
  assign mem_error = merr_cfg;
  assign mem_rdata = dev_mem[mem_addr];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) dev_mem[i] <= 8'(i) ^ 8'h3C;
    end else if (mem_ce && mem_wren && mem_ready && !mem_error) begin
      dev_mem[mem_addr] <= mem_wdata;
    end
    ce_cnt <= mem_ce ? ce_cnt + 1 : 0;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Expected outcome of one transfer, from the transfer rules alone.
  task automatic ref_xfer(input logic wr, input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] w, input int dly, input logic merr,
                          output int rc, output logic e, output int ce, output logic [7:0] rd);
    if (int'(a) >= DEPTH) begin
      rc = 2;
      e  = 1'b1;
      ce = 0;
    end else begin
      if (dly < TMO) begin
        ce = dly + 1;
        e  = merr;
        if (merr) begin
          if (!wr) ref_rdata = 8'h00;
        end else if (wr) begin
          ref_mem[a] = d;
        end else begin
          ref_rdata = ref_mem[a];
        end
      end else begin
        ce = TMO;
        e  = 1'b1;
      end
      rc = 2 + int'(w) + ce;
    end
    rd = ref_rdata;
  endtask

  // Drives one transfer; cycle 0 is the setup cycle. Returns on the ready cycle.
  task automatic xfer(input logic wr, input logic [7:0] a, input logic [7:0] d,
                      input logic [7:0] w, input int dly, input logic merr,
                      output int rc, output logic e, output int ce_n, output int wr_n,
                      output int rd_n, output logic [7:0] rd, output logic stray);
    int limit;
    rc = -1; e = 1'b0; ce_n = 0; wr_n = 0; rd_n = 0; rd = '0; stray = 1'b0;
    limit = 2 + int'(w) + TMO + 6;
    @(posedge clk); #1;
    sel = ID; enable = 1'b0; write = wr; addr = a; wdata = d; wait_cycles = w;
    delay_cfg = dly; merr_cfg = merr;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (mem_ce) ce_n++;
      if (mem_wren) wr_n++;
      if (mem_rden) rd_n++;
      if (error && !ready) stray = 1'b1;
      if (ready) begin
        rc = c; e = error; rd = rdata;
        break;
      end
      @(posedge clk); #1;
      if (c == 0) enable = 1'b1;
    end
  endtask

  task automatic run_check(input string tag, input logic wr, input logic [7:0] a,
                           input logic [7:0] d, input logic [7:0] w, input int dly,
                           input logic merr, input int x_rc, input logic x_e, input int x_ce,
                           input logic [7:0] x_rd);
    int rc, ce_n, wr_n, rd_n;
    logic e, stray;
    logic [7:0] rd;
    xfer(wr, a, d, w, dly, merr, rc, e, ce_n, wr_n, rd_n, rd, stray);
    check({tag, " ready_cycle"}, rc, x_rc);
    check({tag, " error"}, 32'(e), 32'(x_e));
    check({tag, " ce_cycles"}, ce_n, x_ce);
    check({tag, " wren_cycles"}, wr_n, wr ? x_ce : 0);
    check({tag, " rden_cycles"}, rd_n, wr ? 0 : x_ce);
    check({tag, " rdata"}, 32'(rd), 32'(x_rd));
    check({tag, " error_without_ready"}, 32'(stray), 32'd0);
  endtask

  task automatic model_and_check(input string tag, input logic wr, input logic [7:0] a,
                                 input logic [7:0] d, input logic [7:0] w, input int dly,
                                 input logic merr);
    int x_rc, x_ce;
    logic x_e;
    logic [7:0] x_rd;
    ref_xfer(wr, a, d, w, dly, merr, x_rc, x_e, x_ce, x_rd);
    run_check(tag, wr, a, d, w, dly, merr, x_rc, x_e, x_ce, x_rd);
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    sel = '0; enable = 1'b0; delay_cfg = 0; merr_cfg = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] w;
    int         dly;
    logic       merr;
    int         x_rc;
    logic       x_e;
    int         x_ce;
    logic [7:0] x_rd;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int n_rdy, n_ce, d_rc, d_ce;
    logic d_e;
    logic [7:0] d_rd;

    //        wr    addr   wdata  W     dly merr  rc err  ce  rdata
    vecs[0]  = '{1'b1, 8'h10, 8'hA5, 8'd0, 0, 1'b0, 3, 1'b0, 1, 8'h00};
    vecs[1]  = '{1'b1, 8'h10, 8'h5A, 8'd0, 0, 1'b0, 3, 1'b0, 1, 8'h00};
    vecs[2]  = '{1'b0, 8'h10, 8'h00, 8'd3, 0, 1'b0, 6, 1'b0, 1, 8'h5A};
    vecs[3]  = '{1'b0, 8'h80, 8'h00, 8'd0, 0, 1'b0, 2, 1'b1, 0, 8'h5A};
    vecs[4]  = '{1'b0, 8'h10, 8'h00, 8'd0, 9, 1'b0, 6, 1'b1, 4, 8'h5A};
    vecs[5]  = '{1'b0, 8'h10, 8'h00, 8'd0, 0, 1'b1, 3, 1'b1, 1, 8'h00};
    vecs[6]  = '{1'b0, 8'h20, 8'h00, 8'd2, 2, 1'b0, 7, 1'b0, 3, 8'h1C};
    vecs[7]  = '{1'b1, 8'h7F, 8'hC3, 8'd1, 3, 1'b0, 7, 1'b0, 4, 8'h1C};
    vecs[8]  = '{1'b0, 8'h7F, 8'h00, 8'd0, 0, 1'b0, 3, 1'b0, 1, 8'hC3};
    vecs[9]  = '{1'b1, 8'h55, 8'h99, 8'd0, 0, 1'b1, 3, 1'b1, 1, 8'hC3};
    vecs[10] = '{1'b0, 8'h55, 8'h00, 8'd0, 0, 1'b0, 3, 1'b0, 1, 8'h69};
    vecs[11] = '{1'b1, 8'hFF, 8'h11, 8'd2, 0, 1'b0, 2, 1'b1, 0, 8'h69};

    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h3C;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset ready", 32'(ready), 0);
    check("reset error", 32'(error), 0);
    check("reset strobes", {29'd0, mem_ce, mem_wren, mem_rden}, 0);
    check("reset rdata", 32'(rdata), 0);
    check("reset mem_addr", 32'(mem_addr), 0);
    check("reset mem_wdata", 32'(mem_wdata), 0);
    @(posedge clk); #1;
    reset = 1'b0; mem_init = 1'b0;
    idle(1);

    foreach (vecs[i]) begin
      ref_xfer(vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].w, vecs[i].dly, vecs[i].merr,
               d_rc, d_e, d_ce, d_rd);
      run_check($sformatf("vec%0d", i), vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].w,
                vecs[i].dly, vecs[i].merr, vecs[i].x_rc, vecs[i].x_e, vecs[i].x_ce,
                vecs[i].x_rd);
      idle(1);
    end

    for (int i = 0; i < 40; i++) begin
      model_and_check($sformatf("rand%0d", i), 1'($urandom_range(0, 1)),
                      8'($urandom_range(0, 159)), 8'($urandom), 8'($urandom_range(0, 4)),
                      int'($urandom_range(0, 6)), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(0, 2)));
    end
    idle(1);

    // Abort during WAIT by switching sel to another slave
    @(posedge clk); #1;
    sel = ID; enable = 1'b0; write = 1'b0; addr = 8'h10; wait_cycles = 8'd5; delay_cfg = 0;
    n_rdy = 0; n_ce = 0;
    for (int c = 1; c < 15; c++) begin
      @(posedge clk); #1;
      if (c == 1) enable = 1'b1;
      if (c == 4) sel = 2'd2;
      @(negedge clk);
      if (ready) n_rdy++;
      if (mem_ce || mem_wren || mem_rden) n_ce++;
    end
    check("abort ready_pulses", n_rdy, 0);
    check("abort mem_strobes", n_ce, 0);
    check("abort rdata_kept", 32'(rdata), 32'(ref_rdata));
    idle(1);

    // Back-to-back writes, then enable without a setup cycle
    model_and_check("b2b_first", 1'b1, 8'h40, 8'hDE, 8'd0, 0, 1'b0);
    model_and_check("b2b_second", 1'b1, 8'h41, 8'hAD, 8'd1, 0, 1'b0);
    @(posedge clk); #1;
    sel = ID; enable = 1'b1; write = 1'b1; addr = 8'h42; wdata = 8'hEE; wait_cycles = 8'd0;
    n_rdy = 0; n_ce = 0;
    repeat (8) begin
      @(negedge clk);
      if (ready) n_rdy++;
      if (mem_ce) n_ce++;
    end
    check("nosetup ready_pulses", n_rdy, 0);
    check("nosetup mem_ce", n_ce, 0);
    idle(1);
    model_and_check("b2b_readback41", 1'b0, 8'h41, 8'h00, 8'd0, 0, 1'b0);
    idle(1);
    model_and_check("nosetup_readback42", 1'b0, 8'h42, 8'h00, 8'd0, 0, 1'b0);
    idle(1);

    // Reset asserted while in ACCESS
    @(posedge clk); #1;
    sel = ID; enable = 1'b0; write = 1'b1; addr = 8'h30; wdata = 8'h77; wait_cycles = 8'd0;
    delay_cfg = 20;
    @(posedge clk); #1;
    enable = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_access mem_wren_before", 32'(mem_wren), 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_access ready", 32'(ready), 0);
    check("rst_access error", 32'(error), 0);
    check("rst_access strobes", {29'd0, mem_ce, mem_wren, mem_rden}, 0);
    check("rst_access rdata", 32'(rdata), 0);
    check("rst_access mem_addr", 32'(mem_addr), 0);
    check("rst_access mem_wdata", 32'(mem_wdata), 0);
    @(posedge clk); #1;
    reset = 1'b0; sel = '0; enable = 1'b0; delay_cfg = 0;
    ref_rdata = 8'h00;
    n_rdy = 0;
    repeat (6) begin
      @(negedge clk);
      if (ready) n_rdy++;
    end
    check("rst_access no_response", n_rdy, 0);
    model_and_check("post_reset_read30", 1'b0, 8'h30, 8'h00, 8'd0, 0, 1'b0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
